// File: rtl/ser_pkg.sv
// ser_pkg: shared state encoding and default geometry for the serializer/deserializer pair
package ser_pkg;
  localparam int SER_DATA_WIDTH = 4;
  localparam int SER_FIFO_DEPTH = 2;
  typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/ser_fifo.sv
// ser_fifo: synchronous holding FIFO with registered occupancy, full/empty and ready flags
module ser_fifo
  import ser_pkg::*;
#(
  parameter int W     = SER_DATA_WIDTH,
  parameter int DEPTH = SER_FIFO_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic         ready
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt, cnt_n;
  logic wr, rd;
  assign wr = push & ~full;
  assign rd = pop & ~empty;
  assign rdata = mem[rp];
  assign cnt_n = cnt + (AW+1)'(wr) - (AW+1)'(rd);
  always_ff @(posedge clk)
    if (wr) mem[wp] <= wdata;
  // ready is held low through reset so it only rises on the first edge after release
  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      cnt   <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
      ready <= 1'b0;
    end else begin
      wp    <= wr ? wp + 1'b1 : wp;
      rp    <= rd ? rp + 1'b1 : rp;
      cnt   <= cnt_n;
      full  <= cnt_n == (AW+1)'(DEPTH);
      empty <= cnt_n == '0;
      ready <= cnt_n < (AW+1)'(DEPTH);
    end
  end
endmodule

// File: rtl/nibble_serializer.sv
// nibble_serializer: FIFO-buffered parallel-to-serial converter, LSB first, back-to-back frames
module nibble_serializer
  import ser_pkg::*;
#(
  parameter int DATA_WIDTH = SER_DATA_WIDTH,
  parameter int FIFO_DEPTH = SER_FIFO_DEPTH
) (
  input  logic                  fastClk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  inValid,
  output logic                  inReady,
  output logic                  dataOut,
  output logic                  control,
  output logic                  busy
);
  localparam int CW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [DATA_WIDTH-1:0] sreg, sreg_n, head;
  logic push, pop, full, empty;
  assign push = inValid & inReady & ~full & ~reset;
  ser_fifo #(.W(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(fastClk), .rst(reset), .push(push), .pop(pop), .wdata(dataIn),
    .rdata(head), .full(full), .empty(empty), .ready(inReady)
  );
  // frame boundary (idle or last bit) is the only place a new word can be loaded
  always_comb begin
    pop     = 1'b0;
    state_n = state;
    cnt_n   = cnt;
    sreg_n  = sreg;
    if (state == IDLE || cnt == CW'(DATA_WIDTH-1)) begin
      pop     = ~empty;
      state_n = empty ? IDLE : SHIFT;
      cnt_n   = '0;
      sreg_n  = empty ? '0 : head;
    end else begin
      cnt_n  = cnt + 1'b1;
      sreg_n = sreg >> 1;
    end
  end
  always_ff @(posedge fastClk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      sreg    <= '0;
      dataOut <= 1'b0;
      control <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      sreg    <= sreg_n;
      dataOut <= state_n == SHIFT && sreg_n[0];
      control <= state_n == SHIFT && cnt_n == '0;
      busy    <= state_n == SHIFT;
    end
  end
endmodule

// File: tb/tb_nibble_serializer.sv
// tb_nibble_serializer: random and directed stimulus against a bit-queue reference model
module tb_nibble_serializer;
  localparam int W = 4;
  localparam int DEPTH = 2;
  typedef struct packed {logic b; logic first;} bit_t;
  logic fastClk = 0, reset = 1, inValid = 0;
  logic [W-1:0] dataIn = '0;
  logic inReady, dataOut, control, busy;
  int n_cmp = 0, n_bad = 0;
  bit_t bq[$];
  logic [W-1:0] pend[$], acc_q[$], rx[$];
  logic [W-1:0] cur = '0;
  int occ = 0, rxi = 0;
  logic exp_ready = 0;

  nibble_serializer #(.DATA_WIDTH(W), .FIFO_DEPTH(DEPTH)) dut (
    .fastClk(fastClk), .reset(reset), .dataIn(dataIn), .inValid(inValid),
    .inReady(inReady), .dataOut(dataOut), .control(control), .busy(busy)
  );

  always #5 fastClk = ~fastClk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // words accepted at one edge become visible as a bit stream from the next edge on
  task automatic step();
    logic rst_s, v;
    logic [W-1:0] d;
    bit_t e;
    rst_s = reset;
    v = inValid;
    d = dataIn;
    @(posedge fastClk);
    #1;
    if (rst_s) begin
      bq.delete(); pend.delete(); acc_q.delete(); rx.delete();
      occ = 0; rxi = 0; exp_ready = 0;
      check("rst_dataOut", dataOut, 0);
      check("rst_control", control, 0);
      check("rst_busy", busy, 0);
      check("rst_inReady", inReady, 0);
    end else begin
      foreach (pend[j])
        for (int i = 0; i < W; i++) bq.push_back('{b: pend[j][i], first: i == 0});
      pend.delete();
      if (v && exp_ready) begin
        pend.push_back(d);
        acc_q.push_back(d);
        occ++;
      end
      if (bq.size() > 0) begin
        e = bq.pop_front();
        if (e.first) occ--;
        check("busy", busy, 1);
        check("dataOut", dataOut, e.b);
        check("control", control, e.first);
      end else begin
        check("idle_busy", busy, 0);
        check("idle_dataOut", dataOut, 0);
        check("idle_control", control, 0);
      end
      exp_ready = occ < DEPTH;
      check("inReady", inReady, exp_ready);
      if (busy) begin
        if (control) rxi = 0;
        cur[rxi] = dataOut;
        rxi++;
        if (rxi == W) begin
          rx.push_back(cur);
          rxi = 0;
        end
      end
    end
  endtask

  task automatic send(input logic [W-1:0] w);
    int b;
    logic acc;
    b = 0;
    inValid = 1;
    dataIn = w;
    do begin
      acc = exp_ready;
      step();
      b++;
    end while (!acc && b < 50);
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int b;
    b = 0;
    inValid = 0;
    while ((bq.size() > 0 || pend.size() > 0) && b < 200) begin
      step();
      b++;
    end
    if (b >= 200) check("drain_timeout", 0, 1);
    step();
    step();
  endtask

  task automatic compare_rx(input string tag);
    check({tag, "_count"}, rx.size(), acc_q.size());
    for (int i = 0; i < rx.size() && i < acc_q.size(); i++) check({tag, "_word"}, rx[i], acc_q[i]);
    rx.delete();
    acc_q.delete();
  endtask

  initial begin
    reset = 1;
    inValid = 1;
    dataIn = 4'hC;
    repeat (4) step();
    reset = 0;
    inValid = 0;
    step();
    check("ready_after_release", inReady, 1);

    send(4'b1011);
    drain();
    compare_rx("single");

    send(4'hA);
    send(4'h5);
    send(4'h3);
    drain();
    compare_rx("b2b");

    for (int i = 0; i < 32; i++) begin
      inValid = 0;
      repeat ($urandom_range(0, 3)) step();
      send(4'($urandom));
    end
    drain();
    compare_rx("random");

    send(4'hF);
    send(4'h6);
    inValid = 0;
    step();
    reset = 1;
    step();
    reset = 0;
    repeat (6) step();
    check("abort_no_rx", rx.size(), 0);
    send(4'h9);
    drain();
    compare_rx("post_reset");

    inValid = 1;
    for (int i = 0; i < 24; i++) begin
      dataIn = 4'($urandom);
      step();
    end
    drain();
    compare_rx("full_pop");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
